dvc_tmr_seg7: RTL and testbench
===============================

Name: dvc_tmr_seg7

Overview:
Peripheral sub-block of the MIPS device controller. It holds a loadable, reloading 32-bit interval timer that raises a one-cycle interrupt request, and a combinational hex-to-7-segment decoder that drives two digits from one byte. The timer is controlled by the device command register and the store/load decode in the parent. Its count is readable back through the parent's data bus mux.

Parameters:
CNT_W, 32, timer counter and reload register width. Must equal the din width.

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst  in  1  reset; one clock; reset is synchronous and active-high
clr  in  1  timer clear (command bit 7)
ld  in  1  load strobe; din is written to counter and reload register
tmr_en  in  1  count enable (command bit 8)
din  in  32  load value
seg_data  in  8  byte to display
tmr_req  out  1  registered one-cycle timer interrupt request
cntr_o  out  32  current counter value (direct register output)
seg7led1  out  7  low-nibble digit (seg_data[3:0]), active-low, bit0=a..bit6=g
seg7led2  out  7  high-nibble digit (seg_data[7:4]), same encoding

Behaviour:
- State: count[31:0], reload[31:0], tmr_req.
- On reset: count=0, reload=0, tmr_req=0.
- Per rising edge, the first matching condition applies:
  1. rst: reset all state as above.
  2. clr: count=0; tmr_req=0; reload is kept.
  3. ld: count=din; reload=din; tmr_req=0. ld wins over a terminal count in the same cycle.
  4. tmr_en and count==0: count=reload; tmr_req=1.
  5. tmr_en and count!=0: count=count-1; tmr_req=0.
  6. Otherwise: count holds; tmr_req=0.
- Request timing:
  - tmr_req is high for exactly one cycle, in the same cycle that cntr_o first shows the reloaded value.
  - Request period = reload+1 enabled cycles.
  - reload=0 with tmr_en held high gives tmr_req=1 on every cycle.
- Deasserting tmr_en freezes the count. Re-enabling resumes from the held value.
- No overflow or wrap beyond the reload. Decrement is modulo 2^32 but never underflows, because 0 triggers a reload.
- cntr_o = count at all times, with no extra latency.
- Decoder:
  - Purely combinational with no reset dependence; each output is valid in the same cycle as its input.
  - Encoding (hex, active-low, {g,f,e,d,c,b,a}): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
  - Every one of the 16 nibble values maps to a defined pattern; no X outputs.

Test Plan:
- Reset then idle: hold rst=1 for 2 cycles, release with tmr_en=0 -> cntr_o=0 and tmr_req=0 for 10 cycles.
- Load and count: ld with din=3 for one cycle, then tmr_en=1 -> cntr_o sequence 3,2,1,0,3,2,1,0,3. tmr_req=1 exactly in the cycles showing the second and third 3 (period 4).
- Freeze and clear: after loading 10 and counting to 7, drop tmr_en for 5 cycles -> cntr_o stays 7, tmr_req=0. Then assert clr for one cycle -> cntr_o=0. Re-enable -> next cycle cntr_o=10 with tmr_req=1 (reload retained).
- Priority: assert ld(din=5) in the same cycle count==0 with tmr_en=1 -> cntr_o=5, tmr_req=0. Assert clr with ld together -> cntr_o=0. Assert rst with clr/ld -> cntr_o=0, and the reload is cleared.
- reload=0: ld din=0, tmr_en=1 -> tmr_req=1 every cycle and cntr_o=0. Then ld din=0xFFFFFFFF -> decrements 0xFFFFFFFF, 0xFFFFFFFE, ... with no request.
- Decoder sweep: seg_data=0x00..0xFF, all 256 values -> seg7led1 matches the table for the low nibble and seg7led2 for the high nibble. Spot checks: 0x3A -> seg7led2=30, seg7led1=08. 0xF0 -> 0E, 40.

Source files
------------

// File: rtl/dvc_tmr_seg7.sv
// Reloading down-counter with one-cycle interrupt request, plus dual hex-to-7-segment decoder.
// Timer state updates one clock after its controls; decoder is combinational; no backpressure.
module dvc_tmr_seg7 #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             ld,
    input  logic             tmr_en,
    input  logic [CNT_W-1:0] din,
    input  logic [7:0]       seg_data,
    output logic             tmr_req,
    output logic [CNT_W-1:0] cntr_o,
    output logic [6:0]       seg7led1,
    output logic [6:0]       seg7led2
);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] reload;

    // Zero reloads instead of decrementing, so the counter never underflows.
    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            reload  <= '0;
            tmr_req <= 1'b0;
        end else if (clr) begin
            count   <= '0;
            tmr_req <= 1'b0;
        end else if (ld) begin
            count   <= din;
            reload  <= din;
            tmr_req <= 1'b0;
        end else if (tmr_en && (count == '0)) begin
            count   <= reload;
            tmr_req <= 1'b1;
        end else if (tmr_en) begin
            count   <= count - 1'b1;
            tmr_req <= 1'b0;
        end else begin
            tmr_req <= 1'b0;
        end
    end

    assign cntr_o = count;

    function automatic logic [6:0] hex2seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    assign seg7led1 = hex2seg(seg_data[3:0]);
    assign seg7led2 = hex2seg(seg_data[7:4]);

endmodule

// File: tb/tb_dvc_tmr_seg7.sv
// Directed-vector bench for the interval timer and the 7-segment decoder.
module tb_dvc_tmr_seg7;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        ld;
    logic        tmr_en;
    logic [31:0] din;
    logic [7:0]  seg_data;
    logic        tmr_req;
    logic [31:0] cntr_o;
    logic [6:0]  seg7led1;
    logic [6:0]  seg7led2;

    int n_checks;
    int n_pass;

    logic [6:0] seg_ref [16];

    dvc_tmr_seg7 #(.CNT_W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .ld       (ld),
        .tmr_en   (tmr_en),
        .din      (din),
        .seg_data (seg_data),
        .tmr_req  (tmr_req),
        .cntr_o   (cntr_o),
        .seg7led1 (seg7led1),
        .seg7led2 (seg7led2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_tmr(input string tag, input logic [31:0] exp_cnt, input logic exp_req);
        check({tag, ".cnt"}, cntr_o, exp_cnt);
        check({tag, ".req"}, 32'(tmr_req), 32'(exp_req));
    endtask

    logic [31:0] seq_cnt [8];
    logic        seq_req [8];

    initial begin
        n_checks = 0;
        n_pass   = 0;
        seg_ref[0]  = 7'h40; seg_ref[1]  = 7'h79; seg_ref[2]  = 7'h24; seg_ref[3]  = 7'h30;
        seg_ref[4]  = 7'h19; seg_ref[5]  = 7'h12; seg_ref[6]  = 7'h02; seg_ref[7]  = 7'h78;
        seg_ref[8]  = 7'h00; seg_ref[9]  = 7'h10; seg_ref[10] = 7'h08; seg_ref[11] = 7'h03;
        seg_ref[12] = 7'h46; seg_ref[13] = 7'h21; seg_ref[14] = 7'h06; seg_ref[15] = 7'h0E;
        seq_cnt[0] = 2; seq_cnt[1] = 1; seq_cnt[2] = 0; seq_cnt[3] = 3;
        seq_cnt[4] = 2; seq_cnt[5] = 1; seq_cnt[6] = 0; seq_cnt[7] = 3;
        seq_req[0] = 0; seq_req[1] = 0; seq_req[2] = 0; seq_req[3] = 1;
        seq_req[4] = 0; seq_req[5] = 0; seq_req[6] = 0; seq_req[7] = 1;

        rst = 1'b1; clr = 1'b0; ld = 1'b0; tmr_en = 1'b0; din = '0; seg_data = '0;

        // Reset then idle
        tick(); tick();
        check_tmr("reset", 32'd0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_tmr("idle", 32'd0, 1'b0);
        end

        // Load 3 and count: request on each reload, period 4
        ld = 1'b1; din = 32'd3;
        tick();
        check_tmr("load3", 32'd3, 1'b0);
        ld = 1'b0; tmr_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_tmr($sformatf("seq%0d", i), seq_cnt[i], seq_req[i]);
        end

        // Freeze, clear, re-enable from retained reload
        ld = 1'b1; din = 32'd10;
        tick();
        check_tmr("load10", 32'd10, 1'b0);
        ld = 1'b0;
        tick(); tick(); tick();
        check_tmr("cnt7", 32'd7, 1'b0);
        tmr_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_tmr("frozen", 32'd7, 1'b0);
        end
        clr = 1'b1;
        tick();
        check_tmr("clr", 32'd0, 1'b0);
        clr = 1'b0; tmr_en = 1'b1;
        tick();
        check_tmr("reen_reload", 32'd10, 1'b1);
        tick();
        check_tmr("reen_dec", 32'd9, 1'b0);

        // Priority: ld beats terminal count
        ld = 1'b1; din = 32'd1;
        tick();
        ld = 1'b0;
        tick();
        check_tmr("at_zero", 32'd0, 1'b0);
        ld = 1'b1; din = 32'd5;
        tick();
        check_tmr("ld_over_tc", 32'd5, 1'b0);
        // clr beats ld; reload stays 5
        clr = 1'b1; ld = 1'b1; din = 32'd9;
        tick();
        check_tmr("clr_over_ld", 32'd0, 1'b0);
        clr = 1'b0; ld = 1'b0;
        tick();
        check_tmr("reload_kept", 32'd5, 1'b1);
        // rst beats everything and clears reload
        rst = 1'b1; clr = 1'b1; ld = 1'b1; din = 32'd7;
        tick();
        check_tmr("rst_over_all", 32'd0, 1'b0);
        rst = 1'b0; clr = 1'b0; ld = 1'b0;
        tick();
        check_tmr("reload_cleared", 32'd0, 1'b1);

        // reload=0: request every enabled cycle
        ld = 1'b1; din = 32'd0;
        tick();
        check_tmr("ld0", 32'd0, 1'b0);
        ld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_tmr("rl0_every", 32'd0, 1'b1);
        end

        // Max load decrements without request
        ld = 1'b1; din = 32'hFFFF_FFFF;
        tick();
        check_tmr("ldmax", 32'hFFFF_FFFF, 1'b0);
        ld = 1'b0;
        tick();
        check_tmr("max_dec1", 32'hFFFF_FFFE, 1'b0);
        tick();
        check_tmr("max_dec2", 32'hFFFF_FFFD, 1'b0);
        tick();
        check_tmr("max_dec3", 32'hFFFF_FFFC, 1'b0);
        tmr_en = 1'b0;

        // Decoder sweep
        for (int v = 0; v < 256; v++) begin
            seg_data = 8'(v);
            #1;
            check($sformatf("seg_lo_%02h", v), 32'(seg7led1), 32'(seg_ref[v % 16]));
            check($sformatf("seg_hi_%02h", v), 32'(seg7led2), 32'(seg_ref[v / 16]));
        end
        seg_data = 8'h3A;
        #1;
        check("spot3A_hi", 32'(seg7led2), 32'h30);
        check("spot3A_lo", 32'(seg7led1), 32'h08);
        seg_data = 8'hF0;
        #1;
        check("spotF0_hi", 32'(seg7led2), 32'h0E);
        check("spotF0_lo", 32'(seg7led1), 32'h40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
